lcd_char_ctrl: RTL and testbench

HD44780-compatible write controller for the 16x2 character LCD on the game board. After power-up it runs the controller initialisation sequence by itself. It then accepts character and command bytes from the game logic over a valid/ready handshake and generates all bus timing: setup, the enable pulse, hold, and the per-instruction execution delay. The LCD is write-only in this design, so RW is held low and the busy flag is never read.

---
 rtl/lcd_pkg.sv | 70 +++++++
 rtl/lcd_char_ctrl_if.sv | 17 +
 rtl/lcd_write_engine.sv | 111 +++++++++++
 rtl/lcd_char_ctrl.sv | 153 +++++++++++++++
 tb/tb_lcd_char_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared types and constants for the HD44780 character LCD write controller:
// write-engine state encoding, top-level phase encoding, HD44780 instruction
// bytes, and the six-entry power-up initialisation ROM.
// -----------------------------------------------------------------------------
package lcd_pkg;

    // Bus-cycle states. The top level owns power-up; the write engine walks
    // IDLE -> SETUP -> EN -> HOLD -> WAIT for every byte it is given.
    typedef enum logic [2:0] {
        ST_PWR,
        ST_IDLE,
        ST_SETUP,
        ST_EN,
        ST_HOLD,
        ST_WAIT
    } state_t;

    // Top-level sequencing phase: who is feeding the write engine.
    typedef enum logic [1:0] {
        PH_PWR,   // power-up delay
        PH_INIT,  // replaying the init ROM
        PH_IDLE,  // ready for a game-logic request
        PH_USER   // user write in flight
    } phase_t;

    // HD44780 instruction bytes used during initialisation.
    localparam logic [7:0] FUNC_SET_8B2L = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] DISP_ON       = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CLEAR         = 8'h01;  // clear display
    localparam logic [7:0] ENTRY_INC     = 8'h06;  // increment, no shift

    // Which execution delay follows a write.
    typedef enum logic [1:0] {
        WS_INIT,
        WS_EXEC,
        WS_CLEAR
    } wait_sel_t;

    typedef struct packed {
        logic [7:0] data;
        wait_sel_t  ws;
    } init_entry_t;

    localparam int INIT_LEN = 6;

    // Init ROM: three function-set writes (the controller may still be in
    // 4-bit mode at power-up), then display on, clear, entry mode.
    function automatic init_entry_t init_rom(input logic [2:0] idx);
        init_entry_t e;
        case (idx)
            3'd0, 3'd1, 3'd2: e = '{data: FUNC_SET_8B2L, ws: WS_INIT};
            3'd3:             e = '{data: DISP_ON,       ws: WS_EXEC};
            3'd4:             e = '{data: CLEAR,         ws: WS_CLEAR};
            default:          e = '{data: ENTRY_INC,     ws: WS_EXEC};
        endcase
        return e;
    endfunction

    // Clear (0x01) and return-home (0x02/0x03) are the only slow instructions.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_char_ctrl_if.sv
// -----------------------------------------------------------------------------
// lcd_char_ctrl_if
// Valid/ready request channel from the game logic to the LCD controller.
//   req_valid : request present (master -> slave)
//   req_ready : controller can accept (slave -> master)
//   req_rs    : 0 = instruction, 1 = character data
//   req_data  : byte to write
// -----------------------------------------------------------------------------
interface lcd_char_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rs;
    logic [7:0] req_data;

    modport master (output req_valid, output req_rs, output req_data, input  req_ready);
    modport slave  (input  req_valid, input  req_rs, input  req_data, output req_ready);
endinterface

// File: rtl/lcd_write_engine.sv
// -----------------------------------------------------------------------------
// lcd_write_engine
// Generates one HD44780 bus write: RS/DATA setup, EN pulse, hold, then the
// instruction execution delay. A new write may be started on the same edge
// the previous one finishes, so init writes chain without gaps.
//   clk_clk, reset_reset : clock, synchronous active-high reset
//   start                : load start_rs/start_data/start_wait and begin
//   start_wait           : execution delay in cycles (>= 1)
//   done                 : combinational pulse on the last WAIT cycle
//   lcd_en/rs/data       : registered LCD bus outputs
// -----------------------------------------------------------------------------
module lcd_write_engine
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int EN_CYC    = 25,
    parameter int HOLD_CYC  = 2,
    parameter int CW        = 8
) (
    input  logic          clk_clk,
    input  logic          reset_reset,
    input  logic          start,
    input  logic          start_rs,
    input  logic [7:0]    start_data,
    input  logic [CW-1:0] start_wait,
    output logic          done,
    output logic          lcd_en,
    output logic          lcd_rs,
    output logic [7:0]    lcd_data
);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t SETUP_LAST = cnt_t'(SETUP_CYC - 1);
    localparam cnt_t EN_LAST    = cnt_t'(EN_CYC - 1);
    localparam cnt_t HOLD_LAST  = cnt_t'(HOLD_CYC - 1);

    state_t state, state_next;
    cnt_t   cnt, cnt_next;
    cnt_t   wait_last;
    logic   load;

    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        done       = 1'b0;
        load       = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_next = '0;
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: if (cnt == SETUP_LAST) begin
                cnt_next   = '0;
                state_next = ST_EN;
            end
            ST_EN: if (cnt == EN_LAST) begin
                cnt_next   = '0;
                state_next = ST_HOLD;
            end
            ST_HOLD: if (cnt == HOLD_LAST) begin
                cnt_next   = '0;
                state_next = ST_WAIT;
            end
            ST_WAIT: if (cnt == wait_last) begin
                cnt_next = '0;
                done     = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_SETUP;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            wait_last <= '0;
            lcd_en    <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= 8'h00;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            // EN is registered from the next state so it is glitch-free and
            // high exactly while the engine sits in ST_EN.
            lcd_en <= (state_next == ST_EN);
            if (load) begin
                lcd_rs    <= start_rs;
                lcd_data  <= start_data;
                wait_last <= start_wait - 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_char_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_char_ctrl
// HD44780-compatible write-only controller for the 16x2 character LCD.
// Runs the power-up delay and init sequence, then accepts instruction/data
// bytes over a valid/ready channel and drives the LCD bus timing.
//   clk_clk, reset_reset : clock, synchronous active-high reset
//   bus (slave)          : request channel (req_valid/req_ready/req_rs/req_data)
//   init_done            : init sequence finished, sticky until reset
//   blon_in              : backlight request, registered to lcd_BLON
//   lcd_DATA/EN/RS       : LCD bus; lcd_RW tied 0, lcd_ON tied 1
// -----------------------------------------------------------------------------
module lcd_char_ctrl
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYC = 1_000_000,
    parameter int INIT_CYC    = 250_000,
    parameter int EXEC_CYC    = 2_500,
    parameter int CLEAR_CYC   = 100_000,
    parameter int SETUP_CYC   = 2,
    parameter int EN_CYC      = 25,
    parameter int HOLD_CYC    = 2
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    lcd_char_ctrl_if.slave bus,
    output logic        init_done,
    input  logic        blon_in,
    output logic [7:0]  lcd_DATA,
    output logic        lcd_EN,
    output logic        lcd_RS,
    output logic        lcd_RW,
    output logic        lcd_ON,
    output logic        lcd_BLON
);

    if (POWERUP_CYC < 1 || INIT_CYC < 1 || EXEC_CYC < 1 || CLEAR_CYC < 1 ||
        SETUP_CYC < 1 || EN_CYC < 1 || HOLD_CYC < 1) begin : g_bad_param
        $error("lcd_char_ctrl: all cycle parameters must be >= 1");
    end

    localparam int MAX_CYC = max_int(max_int(max_int(POWERUP_CYC, INIT_CYC),
                                             max_int(EXEC_CYC, CLEAR_CYC)),
                                     max_int(max_int(SETUP_CYC, EN_CYC), HOLD_CYC));
    localparam int CW = $clog2(MAX_CYC) + 1;

    typedef logic [CW-1:0] cnt_t;

    function automatic cnt_t wait_cycles(input wait_sel_t ws);
        case (ws)
            WS_INIT:  return cnt_t'(INIT_CYC);
            WS_CLEAR: return cnt_t'(CLEAR_CYC);
            default:  return cnt_t'(EXEC_CYC);
        endcase
    endfunction

    phase_t      phase, phase_next;
    cnt_t        pwr_cnt;
    logic [2:0]  rom_idx, rom_idx_next;   // next ROM entry to issue
    init_entry_t rom_e;
    logic        ready_q, init_done_q, blon_q;

    logic        eng_start, eng_rs, eng_done;
    logic [7:0]  eng_data;
    cnt_t        eng_wait;

    assign rom_e = init_rom(rom_idx);

    always_comb begin
        phase_next   = phase;
        rom_idx_next = rom_idx;
        eng_start    = 1'b0;
        eng_rs       = 1'b0;
        eng_data     = rom_e.data;
        eng_wait     = wait_cycles(rom_e.ws);
        case (phase)
            PH_PWR: if (pwr_cnt == cnt_t'(POWERUP_CYC - 1)) begin
                eng_start    = 1'b1;
                rom_idx_next = rom_idx + 3'd1;
                phase_next   = PH_INIT;
            end
            PH_INIT: if (eng_done) begin
                if (rom_idx == 3'(INIT_LEN)) begin
                    phase_next = PH_IDLE;
                end else begin
                    // Chain the next init write on the same edge.
                    eng_start    = 1'b1;
                    rom_idx_next = rom_idx + 3'd1;
                end
            end
            PH_IDLE: if (bus.req_valid && ready_q) begin
                eng_start  = 1'b1;
                eng_rs     = bus.req_rs;
                eng_data   = bus.req_data;
                eng_wait   = is_slow_cmd(bus.req_rs, bus.req_data) ? cnt_t'(CLEAR_CYC)
                                                                   : cnt_t'(EXEC_CYC);
                phase_next = PH_USER;
            end
            PH_USER: if (eng_done) begin
                phase_next = PH_IDLE;
            end
            default: phase_next = PH_PWR;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            phase       <= PH_PWR;
            pwr_cnt     <= '0;
            rom_idx     <= 3'd0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
            blon_q      <= 1'b0;
        end else begin
            phase   <= phase_next;
            rom_idx <= rom_idx_next;
            if (phase == PH_PWR) begin
                pwr_cnt <= pwr_cnt + 1'b1;
            end
            // Ready is decoded from the next phase so it is a clean register
            // that rises on the same edge as init_done.
            ready_q <= (phase_next == PH_IDLE);
            if (phase_next == PH_IDLE) begin
                init_done_q <= 1'b1;
            end
            blon_q <= blon_in;
        end
    end

    lcd_write_engine #(
        .SETUP_CYC (SETUP_CYC),
        .EN_CYC    (EN_CYC),
        .HOLD_CYC  (HOLD_CYC),
        .CW        (CW)
    ) u_engine (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .start       (eng_start),
        .start_rs    (eng_rs),
        .start_data  (eng_data),
        .start_wait  (eng_wait),
        .done        (eng_done),
        .lcd_en      (lcd_EN),
        .lcd_rs      (lcd_RS),
        .lcd_data    (lcd_DATA)
    );

    assign bus.req_ready = ready_q;
    assign init_done     = init_done_q;
    assign lcd_BLON      = blon_q;
    assign lcd_RW        = 1'b0;
    assign lcd_ON        = 1'b1;

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lcd_char_ctrl
// Directed self-checking bench for lcd_char_ctrl with shortened timing
// (POWERUP 100, INIT 20, EXEC 10, CLEAR 30, SETUP 2, EN 4, HOLD 2).
// Edge numbering: edge 0 is the last clock edge that samples reset high;
// cyc holds the number of the most recent rising edge, and outputs are
// sampled on the falling edge that follows it.
// -----------------------------------------------------------------------------
module tb_lcd_char_ctrl;

    localparam int POWERUP_CYC = 100;
    localparam int INIT_CYC    = 20;
    localparam int EXEC_CYC    = 10;
    localparam int CLEAR_CYC   = 30;
    localparam int SETUP_CYC   = 2;
    localparam int EN_CYC      = 4;
    localparam int HOLD_CYC    = 2;

    logic       clk_clk     = 1'b0;
    logic       reset_reset = 1'b1;
    logic       blon_in     = 1'b0;
    logic       init_done;
    logic [7:0] lcd_DATA;
    logic       lcd_EN, lcd_RS, lcd_RW, lcd_ON, lcd_BLON;

    lcd_char_ctrl_if bus ();

    lcd_char_ctrl #(
        .POWERUP_CYC (POWERUP_CYC),
        .INIT_CYC    (INIT_CYC),
        .EXEC_CYC    (EXEC_CYC),
        .CLEAR_CYC   (CLEAR_CYC),
        .SETUP_CYC   (SETUP_CYC),
        .EN_CYC      (EN_CYC),
        .HOLD_CYC    (HOLD_CYC)
    ) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .bus         (bus),
        .init_done   (init_done),
        .blon_in     (blon_in),
        .lcd_DATA    (lcd_DATA),
        .lcd_EN      (lcd_EN),
        .lcd_RS      (lcd_RS),
        .lcd_RW      (lcd_RW),
        .lcd_ON      (lcd_ON),
        .lcd_BLON    (lcd_BLON)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct {
        int         start;   // edge on which EN rose
        int         width;   // cycles EN stayed high
        logic       rs;
        logic [7:0] data;
        bit         stable;  // RS/DATA unchanged while EN was high
    } pulse_t;

    pulse_t pulses[$];
    pulse_t cur;
    bit     en_prev = 1'b0;
    int     cyc = 0;
    int     n_checks = 0;
    int     n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one clock and record EN pulses as they complete.
    task automatic tick();
        @(negedge clk_clk);
        cyc++;
        if (lcd_EN) begin
            if (!en_prev) begin
                cur.start  = cyc;
                cur.width  = 0;
                cur.rs     = lcd_RS;
                cur.data   = lcd_DATA;
                cur.stable = 1'b1;
            end
            cur.width++;
            if (lcd_RS !== cur.rs || lcd_DATA !== cur.data) cur.stable = 1'b0;
        end else if (en_prev) begin
            pulses.push_back(cur);
        end
        en_prev = lcd_EN;
    endtask

    task automatic wait_ready(input int budget, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (bus.req_ready) begin
                at_cyc = cyc;
                break;
            end
            tick();
        end
    endtask

    task automatic check_pulse(input string tag, input int idx, input logic rs,
                               input logic [7:0] data, input int start);
        check({tag, " pulse present"}, 32'(pulses.size() > idx), 1);
        if (pulses.size() > idx) begin
            check({tag, " EN width"},  pulses[idx].width, EN_CYC);
            check({tag, " RS"},        pulses[idx].rs, rs);
            check({tag, " DATA"},      pulses[idx].data, data);
            check({tag, " EN start"},  pulses[idx].start, start);
            check({tag, " bus stable"}, pulses[idx].stable, 1);
        end
    endtask

    // Release reset and check the whole init replay, ending with ready seen.
    task automatic run_init(input string tag);
        logic [7:0] exp_data [6]  = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        int         exp_start [6] = '{102, 130, 158, 186, 204, 242};
        int         t;
        reset_reset = 1'b0;
        cyc = 0;
        pulses.delete();
        while (cyc < 257) tick();
        check({tag, " init_done before 258"}, init_done, 0);
        check({tag, " ready before 258"}, bus.req_ready, 0);
        wait_ready(50, t);
        check({tag, " ready rise cycle"}, t, 258);
        check({tag, " init_done with ready"}, init_done, 1);
        check({tag, " init pulse count"}, pulses.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check_pulse($sformatf("%s init %0d", tag, i), i, 1'b0, exp_data[i], exp_start[i]);
        end
    endtask

    // Single request from an idle controller; checks latency and the pulse.
    task automatic send(input string tag, input logic rs, input logic [7:0] data,
                        input int exp_lat);
        int acc, t, n0;
        n0 = pulses.size();
        bus.req_valid = 1'b1;
        bus.req_rs    = rs;
        bus.req_data  = data;
        tick();
        acc = cyc;
        bus.req_valid = 1'b0;
        check({tag, " ready drops"}, bus.req_ready, 0);
        wait_ready(200, t);
        check({tag, " ready latency"}, t - acc, exp_lat);
        check_pulse(tag, n0, rs, data, acc + SETUP_CYC);
    endtask

    initial begin
        int a1, a2, t, n0;
        bus.req_valid = 1'b0;
        bus.req_rs    = 1'b0;
        bus.req_data  = 8'h00;

        // Reset values.
        repeat (3) tick();
        check("reset EN", lcd_EN, 0);
        check("reset RS", lcd_RS, 0);
        check("reset DATA", lcd_DATA, 8'h00);
        check("reset RW", lcd_RW, 0);
        check("reset ON", lcd_ON, 1);
        check("reset BLON", lcd_BLON, 0);
        check("reset ready", bus.req_ready, 0);
        check("reset init_done", init_done, 0);

        // Power-up and init sequence.
        run_init("boot");

        // Backlight: one cycle of latency.
        blon_in = 1'b1;
        #1;
        check("BLON not combinational", lcd_BLON, 0);
        tick();
        check("BLON follows high", lcd_BLON, 1);
        blon_in = 1'b0;
        tick();
        check("BLON follows low", lcd_BLON, 0);

        // Single writes with both wait selections.
        send("char A",   1'b1, 8'h41, 18);
        send("clear",    1'b0, 8'h01, 38);
        send("home",     1'b0, 8'h02, 38);
        send("ddram",    1'b0, 8'h80, 18);
        send("shift 04", 1'b0, 8'h04, 18);
        send("data 01",  1'b1, 8'h01, 18);

        // Back-to-back with valid held; inputs change while EN is high.
        n0 = pulses.size();
        bus.req_valid = 1'b1;
        bus.req_rs    = 1'b1;
        bus.req_data  = 8'h48;
        tick();
        a1 = cyc;
        while (cyc < a1 + 3) tick();
        check("b2b EN high", lcd_EN, 1);
        bus.req_rs   = 1'b0;
        bus.req_data = 8'h49;
        tick();
        check("b2b DATA held", lcd_DATA, 8'h48);
        wait_ready(100, t);
        check("b2b first latency", t - a1, 18);
        tick();
        a2 = cyc;
        bus.req_valid = 1'b0;
        check("b2b second accept", bus.req_ready, 0);
        check("b2b no gap", a2 - a1, 19);
        wait_ready(100, t);
        check("b2b second latency", t - a2, 18);
        check_pulse("b2b first", n0, 1'b1, 8'h48, a1 + SETUP_CYC);
        check_pulse("b2b second", n0 + 1, 1'b0, 8'h49, a2 + SETUP_CYC);

        // Reset while EN is high abandons the write.
        bus.req_valid = 1'b1;
        bus.req_rs    = 1'b1;
        bus.req_data  = 8'h33;
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (lcd_EN) break;
            tick();
        end
        check("abort EN high", lcd_EN, 1);
        reset_reset = 1'b1;
        tick();
        check("abort EN low", lcd_EN, 0);
        check("abort ready", bus.req_ready, 0);
        check("abort init_done", init_done, 0);
        check("abort DATA", lcd_DATA, 8'h00);
        check("abort RS", lcd_RS, 0);

        // Replay with a request held valid throughout init.
        bus.req_valid = 1'b1;
        bus.req_rs    = 1'b1;
        bus.req_data  = 8'h55;
        run_init("replay");
        tick();
        a1 = cyc;
        bus.req_valid = 1'b0;
        check("held accept", bus.req_ready, 0);
        check("held accept cycle", a1, 259);
        wait_ready(200, t);
        check("held latency", t - a1, 18);
        check_pulse("held write", 6, 1'b1, 8'h55, 261);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
